// File: rtl/fetch_queue.sv
// fetch_queue
//
// Decoupled instruction-fetch front end for the 5-stage MIPS pipeline.
// A PC register drives a request/grant/response port to instruction memory
// of arbitrary latency. Returned instructions are pushed into a small FIFO
// that decode drains with a valid/ready handshake. A taken-branch redirect
// from MEM flushes the queue and discards any fetch still in flight.
//
// Only one fetch is outstanding at a time, so peak throughput is one
// instruction every two cycles.
//
// Optional feature: define FETCH_PERF_EN to get the two performance
// counters. Without it, both perf outputs are tied to zero and no counter
// flops are built.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   pc_src         redirect request (taken branch from MEM)
//   add_res        redirect target; the low two bits are ignored
//   imem_req       fetch request to instruction memory
//   imem_addr      word-aligned fetch address
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    memory response valid
//   imem_rdata     memory response instruction
//   d_valid        head entry is available to decode
//   d_ready        decode accepts the head entry
//   d_inst         head instruction
//   d_pc           head instruction address + 4
//   perf_fetched   instructions delivered to decode (FETCH_PERF_EN only)
//   perf_redirects redirect cycles seen (FETCH_PERF_EN only)

module fetch_queue #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] add_res,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [INST_W-1:0] d_inst,
  output logic [ADDR_W-1:0] d_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

  logic              space;
  logic              grant;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_pc;

  // A new fetch is only launched from REQ, where nothing is in flight, so
  // checking the occupancy alone reserves the slot for the outstanding fetch.
  assign space       = (count_q < DEPTH_C);
  assign grant       = (state_q == ST_REQ) && space && imem_gnt;
  assign imem_req    = rst && (state_q == ST_REQ) && space;
  assign imem_addr   = fetch_pc_q;
  assign redirect_pc = add_res & ~ADDR_W'(3);

  // A redirect hides the head entry in the same cycle, so it can never pop.
  assign d_valid = (count_q != '0) && !pc_src;
  assign pop     = d_valid && d_ready;
  assign d_inst  = inst_mem_q[rd_ptr_q];
  assign d_pc    = pc_mem_q[rd_ptr_q];

  // Next-state logic. A redirect wins over both enqueue and pop. The fetch
  // PC already points one word past the outstanding fetch, so it doubles as
  // the captured pc+4 stored alongside the returned instruction.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push       = 1'b0;
    if (pc_src) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      case (state_q)
        ST_REQ:           state_d = grant ? ST_DROP : ST_REQ;
        ST_WAIT, ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        default:          state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (grant) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset: the occupancy count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (pop) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (pc_src) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//
// Scoreboard bench for fetch_queue. The stimulus process drives inputs on
// the falling edge, plays the role of instruction memory, and keeps a
// transaction-level model of the front end (expected fetch PC, one flag for
// an outstanding fetch, a queue of expected decode entries). A separate
// monitor samples the DUT shortly after every falling edge and pops the
// scoreboard whenever decode takes an entry.

module tb_fetch_queue;

  localparam int          ADDR_W     = 32;
  localparam int          INST_W     = 32;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] add_res;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;

  fetch_queue #(
    .ADDR_W    (ADDR_W),
    .INST_W    (INST_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .add_res       (add_res),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .d_inst        (d_inst),
    .d_pc          (d_pc),
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects)
  );

  always #5 clk = ~clk;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  bit          outstanding = 0;
  bit          killed      = 0;
  logic [31:0] exp_pc      = RESET_PC;
  logic [31:0] grant_addr  = '0;
  bit          exp_req     = 0;
  bit          exp_dvalid  = 0;
  logic [31:0] exp_addr    = '0;
  int          model_pops  = 0;
  int          model_redirs = 0;

  bit          mem_pending = 0;
  int          mem_wait    = 0;
  logic [31:0] mem_addr    = '0;
  int          lat_cfg     = 1;

  int          dut_grants  = 0;
  bit          watch_first = 0;
  logic [31:0] first_pc    = '0;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor body: compare outputs against the model and consume the
  // scoreboard on each decode handshake.
  task automatic check_output();
    entry_t e;
    compare("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) begin
      compare("imem_addr", imem_addr, exp_addr);
    end
    compare("d_valid", {31'd0, d_valid}, {31'd0, exp_dvalid});
`ifdef FETCH_PERF_EN
    compare("perf_fetched", perf_fetched, 32'(model_pops));
    compare("perf_redirects", perf_redirects, 32'(model_redirs));
`else
    compare("perf_fetched", perf_fetched, 32'd0);
    compare("perf_redirects", perf_redirects, 32'd0);
`endif
    if (d_valid && d_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got d_pc 0x%08h, expected no entry at %0t", d_pc, $time);
      end else begin
        e = sb.pop_front();
        compare("d_inst", d_inst, e.inst);
        compare("d_pc", d_pc, e.pc4);
        if (watch_first) begin
          first_pc    = d_pc;
          watch_first = 0;
        end
      end
      model_pops++;
    end
  endtask

  always @(negedge clk) begin
    #2;
    check_output();
  end

  // One clock cycle of stimulus: drive inputs, act as memory, then advance
  // the model to the state the coming rising edge should produce.
  task automatic apply_stimulus(input bit ps, input logic [31:0] tgt, input bit g,
                                input bit rdy, input bit spur);
    bit resp;
    bit granted;
    @(negedge clk);
    rst     = 1'b1;
    pc_src  = ps;
    add_res = tgt;
    imem_gnt = g;
    d_ready = rdy;
    if (mem_pending && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_fn(mem_addr);
    end else if (spur && !mem_pending) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    exp_req    = !outstanding && (sb.size() < FIFO_DEPTH);
    exp_dvalid = (sb.size() != 0) && !ps;
    exp_addr   = exp_pc;
    #3;
    if (imem_req && g) dut_grants++;
    granted = exp_req && g;
    resp    = imem_rvalid && outstanding;
    if (ps) model_redirs++;
    if (mem_pending && imem_rvalid) mem_pending = 0;
    else if (mem_pending) mem_wait--;
    if (granted) begin
      mem_pending = 1;
      mem_addr    = imem_addr;
      mem_wait    = (lat_cfg == 0) ? int'($urandom_range(2, 0)) : lat_cfg - 1;
    end
    if (ps) begin
      sb.delete();
      if (granted) begin
        outstanding = 1;
        killed      = 1;
      end else if (resp) begin
        outstanding = 0;
      end else if (outstanding) begin
        killed = 1;
      end
      exp_pc      = tgt & 32'hFFFF_FFFC;
      watch_first = 1;
      first_pc    = 32'hDEAD_BEEF;
    end else if (granted) begin
      outstanding = 1;
      killed      = 0;
      grant_addr  = exp_pc;
      exp_pc      = exp_pc + 32'd4;
    end else if (resp) begin
      outstanding = 0;
      if (!killed) sb.push_back({mem_fn(grant_addr), grant_addr + 32'd4});
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = 1'b0;
      pc_src      = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      d_ready     = 1'b1;
      exp_req     = 0;
      exp_dvalid  = 0;
      sb.delete();
      outstanding  = 0;
      killed       = 0;
      mem_pending  = 0;
      exp_pc       = RESET_PC;
      model_pops   = 0;
      model_redirs = 0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || outstanding) && k < 50) begin
      apply_stimulus(0, 32'h0, 0, 1, 0);
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    pc_src      = 1'b0;
    add_res     = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    d_ready     = 1'b0;
    #1 rst = 1'b0;
    do_reset(3);

    $display("[TB] back-to-back fetch, 1-cycle memory");
    lat_cfg = 1;
    repeat (12) apply_stimulus(0, 32'h0, 1, 1, 0);

    $display("[TB] decode stalled");
    drain();
    dut_grants = 0;
    repeat (20) apply_stimulus(0, 32'h0, 1, 0, 0);
    compare("grants_while_stalled", 32'(dut_grants), 32'(FIFO_DEPTH));
    compare("imem_req_when_full", {31'd0, imem_req}, 32'd0);
    repeat (15) apply_stimulus(0, 32'h0, 1, 1, 0);

    $display("[TB] redirect while waiting");
    drain();
    lat_cfg = 3;
    apply_stimulus(0, 32'h0, 1, 1, 0);
    apply_stimulus(1, 32'h40, 0, 1, 0);
    lat_cfg = 1;
    repeat (12) apply_stimulus(0, 32'h0, 1, 1, 0);
    compare("first_pc_after_wait_redirect", first_pc, 32'h44);

    $display("[TB] redirect with response in same cycle");
    drain();
    apply_stimulus(0, 32'h0, 1, 1, 0);
    apply_stimulus(1, 32'h80, 0, 1, 0);
    repeat (10) apply_stimulus(0, 32'h0, 1, 1, 0);
    compare("first_pc_after_rvalid_redirect", first_pc, 32'h84);

    $display("[TB] unaligned redirect target");
    drain();
    apply_stimulus(1, 32'h43, 0, 1, 0);
    apply_stimulus(0, 32'h0, 0, 1, 0);
    compare("unaligned_target", imem_addr, 32'h40);
    repeat (8) apply_stimulus(0, 32'h0, 1, 1, 0);
    compare("first_pc_after_unaligned", first_pc, 32'h44);

    $display("[TB] reset while waiting with 3 entries queued");
    drain();
    lat_cfg = 3;
    k = 0;
    while (!(sb.size() == 3 && outstanding) && k < 60) begin
      apply_stimulus(0, 32'h0, 1, 0, 0);
      k++;
    end
    if (k >= 60) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL fill_timeout: got %0d entries, expected 3", sb.size());
    end
    do_reset(2);
    lat_cfg = 1;
    apply_stimulus(0, 32'h0, 0, 1, 1);
    repeat (10) apply_stimulus(0, 32'h0, 1, 1, 0);

    $display("[TB] randomized traffic");
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        do_reset(int'($urandom_range(2, 1)));
      end else begin
        apply_stimulus($urandom_range(19, 0) == 0, $urandom, $urandom_range(9, 0) < 7,
                       $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0);
      end
    end
    drain();
    repeat (2) apply_stimulus(0, 32'h0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
